// File: rtl/scr1_imem_pipe_stage_pkg.sv
// IMEM protocol types and widths shared by the IMEM pipe stage and its bench.
// Encodings match the core's memory interface so the slice drops in unchanged.
package scr1_imem_pipe_stage_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  function automatic logic is_misaligned(input logic [SCR1_IMEM_AWIDTH-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/scr1_imem_pipe_stage.sv
// Registered IMEM request slice (optional registered response) between a router port and memory.
// One fetch in flight; misaligned fetches are answered locally with RDY_ER.
module scr1_imem_pipe_stage
  import scr1_imem_pipe_stage_pkg::*;
#(
  parameter bit RESP_REG  = 1'b1,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic                        rst_n,
  input  logic                        clk,
  output logic                        o_core_req_ack,
  input  logic                        i_core_req,
  input  type_scr1_mem_cmd_e          i_core_cmd,
  input  logic [SCR1_IMEM_AWIDTH-1:0] i_core_addr,
  output logic [SCR1_IMEM_DWIDTH-1:0] o_core_rdata,
  output type_scr1_mem_resp_e         o_core_resp,
  input  logic                        i_mem_req_ack,
  output logic                        o_mem_req,
  output type_scr1_mem_cmd_e          o_mem_cmd,
  output logic [SCR1_IMEM_AWIDTH-1:0] o_mem_addr,
  input  logic [SCR1_IMEM_DWIDTH-1:0] i_mem_rdata,
  input  type_scr1_mem_resp_e         i_mem_resp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_RESP,
    ST_ERR
  } state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  state_e                      w_accept_state;
  type_scr1_mem_cmd_e          r_cmd;
  logic [SCR1_IMEM_AWIDTH-1:0] r_addr;
  logic                        w_accept;
  logic                        w_mis;
  logic                        w_mem_done;
  type_scr1_mem_resp_e         w_resp_q;
  logic [SCR1_IMEM_DWIDTH-1:0] w_rdata_q;

  assign w_accept       = i_core_req & o_core_req_ack;
  assign w_mis          = ALIGN_CHK & is_misaligned(i_core_addr);
  assign w_accept_state = w_mis ? ST_ERR : ST_REQ;
  assign w_mem_done     = (i_mem_resp != SCR1_MEM_RESP_NOTRDY);
  assign o_mem_cmd      = r_cmd;
  assign o_mem_addr     = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= SCR1_MEM_CMD_RD;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cmd  <= i_core_cmd;
        r_addr <= i_core_addr;
      end
    end
  end

  generate
    if (RESP_REG) begin : g_resp_reg
      type_scr1_mem_resp_e         r_resp;
      logic [SCR1_IMEM_DWIDTH-1:0] r_rdata;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_resp  <= SCR1_MEM_RESP_NOTRDY;
          r_rdata <= '0;
        end else if ((r_state == ST_DATA) && w_mem_done) begin
          r_resp  <= i_mem_resp;
          r_rdata <= i_mem_rdata;
        end
      end

      assign w_resp_q  = r_resp;
      assign w_rdata_q = r_rdata;
    end else begin : g_resp_pass
      assign w_resp_q  = SCR1_MEM_RESP_NOTRDY;
      assign w_rdata_q = '0;
    end
  endgenerate

  always_comb begin
    w_state_next   = r_state;
    o_core_req_ack = 1'b0;
    o_core_resp    = SCR1_MEM_RESP_NOTRDY;
    o_core_rdata   = '0;
    o_mem_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_core_req_ack = 1'b1;
        if (i_core_req) w_state_next = w_accept_state;
      end
      ST_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_req_ack) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (RESP_REG) begin
          if (w_mem_done) w_state_next = ST_RESP;
        end else begin
          // Passthrough: an OK response cycle doubles as the next accept cycle
          o_core_resp  = i_mem_resp;
          o_core_rdata = i_mem_rdata;
          if (i_mem_resp == SCR1_MEM_RESP_RDY_OK) begin
            o_core_req_ack = 1'b1;
            w_state_next   = i_core_req ? w_accept_state : ST_IDLE;
          end else if (w_mem_done) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        o_core_resp = w_resp_q;
        if (w_resp_q == SCR1_MEM_RESP_RDY_OK) begin
          o_core_rdata   = w_rdata_q;
          o_core_req_ack = 1'b1;
          w_state_next   = i_core_req ? w_accept_state : ST_IDLE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        o_core_resp  = SCR1_MEM_RESP_RDY_ER;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef SCR1_TRGT_SIMULATION
  a_mem_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (o_mem_req & !i_mem_req_ack) |=> ($stable(o_mem_addr) && $stable(o_mem_cmd)));
  a_core_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(i_core_req));
`endif

endmodule

// File: tb/tb_scr1_imem_pipe_stage.sv
// Bench for scr1_imem_pipe_stage: four instances cover RESP_REG x ALIGN_CHK (index bit0=RESP_REG, bit1=ALIGN_CHK).
// A transaction-level model predicts each response value and its cycle from the accept cycle and memory delays.
module tb_scr1_imem_pipe_stage;
  import scr1_imem_pipe_stage_pkg::*;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                        core_req   [ND];
  type_scr1_mem_cmd_e          core_cmd   [ND];
  logic [SCR1_IMEM_AWIDTH-1:0] core_addr  [ND];
  logic                        core_ack   [ND];
  logic [SCR1_IMEM_DWIDTH-1:0] core_rdata [ND];
  type_scr1_mem_resp_e         core_resp  [ND];
  logic                        mem_ack    [ND];
  logic                        mem_req    [ND];
  type_scr1_mem_cmd_e          mem_cmd    [ND];
  logic [SCR1_IMEM_AWIDTH-1:0] mem_addr   [ND];
  logic [SCR1_IMEM_DWIDTH-1:0] mem_rdata  [ND];
  type_scr1_mem_resp_e         mem_resp   [ND];

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      scr1_imem_pipe_stage #(
        .RESP_REG (bit'(gi % 2)),
        .ALIGN_CHK(bit'(gi / 2))
      ) u_dut (
        .rst_n         (rst_n),
        .clk           (clk),
        .o_core_req_ack(core_ack[gi]),
        .i_core_req    (core_req[gi]),
        .i_core_cmd    (core_cmd[gi]),
        .i_core_addr   (core_addr[gi]),
        .o_core_rdata  (core_rdata[gi]),
        .o_core_resp   (core_resp[gi]),
        .i_mem_req_ack (mem_ack[gi]),
        .o_mem_req     (mem_req[gi]),
        .o_mem_cmd     (mem_cmd[gi]),
        .o_mem_addr    (mem_addr[gi]),
        .i_mem_rdata   (mem_rdata[gi]),
        .i_mem_resp    (mem_resp[gi])
      );
    end
  endgenerate

  typedef struct {
    int                 d;
    logic [31:0]        addr;
    type_scr1_mem_cmd_e cmd;
    int                 aw;   // cycles mem_req waits before ack
    int                 rw;   // extra NOTRDY cycles after ack
    bit                 er;   // memory answers RDY_ER
    logic [31:0]        data;
  } req_t;

  typedef struct {
    req_t                r;
    type_scr1_mem_resp_e exp_resp;
    int                  exp_lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_en = 1'b0;
  int stray_pct = 10;

  bit                  gen_pend [ND];
  req_t                gen      [ND];
  bit                  out_v    [ND];
  req_t                out_r    [ND];
  bit                  lerr     [ND];
  bit                  ms_v     [ND];
  int                  acc_c    [ND];
  int                  exp_c    [ND];
  int                  mack_c   [ND];
  int                  mresp_c  [ND];
  type_scr1_mem_resp_e exp_resp [ND];
  int                  obs_lat  [ND];
  type_scr1_mem_resp_e obs_resp [ND];
  logic [31:0]         obs_data [ND];
  int                  done_cnt [ND];
  req_t                dq[$];
  int                  acc_hist[$];
  vec_t                vt[9];

  function automatic bit rr(input int d);
    return d[0];
  endfunction

  function automatic bit ac(input int d);
    return d[1];
  endfunction

  function automatic req_t mk(input int d, input logic [31:0] addr, input type_scr1_mem_cmd_e cmd,
                              input int aw, input int rw, input bit er, input logic [31:0] data);
    req_t r;
    r.d = d; r.addr = addr; r.cmd = cmd; r.aw = aw; r.rw = rw; r.er = er; r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req(input int d);
    req_t r;
    r.d    = d;
    r.addr = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 4) == 0) r.addr[1:0] = 2'($urandom_range(1, 3));
    r.cmd  = ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    r.aw   = $urandom_range(0, 3);
    r.rw   = $urandom_range(0, 3);
    r.er   = ($urandom_range(0, 5) == 0);
    r.data = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d act=%08h exp=%08h", name, d, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      gen_pend[d] = 1'b0; out_v[d] = 1'b0; ms_v[d] = 1'b0;
    end
    dq.delete();
  endtask

  task automatic check_dut(input int d);
    bit   had;
    bit   deliver;
    logic exp_ack;
    logic exp_mreq;
    had = out_v[d];
    deliver = 1'b0;
    if (had && core_resp[d] != SCR1_MEM_RESP_NOTRDY && obs_lat[d] < 0) begin
      obs_lat[d]  = cyc - acc_c[d];
      obs_resp[d] = core_resp[d];
      obs_data[d] = core_rdata[d];
    end
    if (had && cyc == exp_c[d]) begin
      chk("core_resp", d, 32'(core_resp[d]), 32'(exp_resp[d]));
      if (exp_resp[d] == SCR1_MEM_RESP_RDY_OK) chk("core_rdata", d, core_rdata[d], out_r[d].data);
      deliver  = 1'b1;
      out_v[d] = 1'b0;
      done_cnt[d]++;
      $display("txn dut=%0d addr=%08h cmd=%0d resp=%0d data=%08h lat=%0d",
               d, out_r[d].addr, out_r[d].cmd, core_resp[d], core_rdata[d], cyc - acc_c[d]);
    end else begin
      chk("core_resp_notrdy", d, 32'(core_resp[d]), 32'(SCR1_MEM_RESP_NOTRDY));
    end
    exp_ack = had ? (deliver && exp_resp[d] == SCR1_MEM_RESP_RDY_OK) : 1'b1;
    chk("core_req_ack", d, 32'(core_ack[d]), 32'(exp_ack));
    exp_mreq = had && !lerr[d] && (cyc <= mack_c[d]);
    chk("mem_req", d, 32'(mem_req[d]), 32'(exp_mreq));
    if (exp_mreq && mem_req[d]) begin
      chk("mem_addr", d, mem_addr[d], out_r[d].addr);
      chk("mem_cmd", d, 32'(mem_cmd[d]), 32'(out_r[d].cmd));
    end
    if (rr(d) && core_resp[d] != SCR1_MEM_RESP_RDY_OK) chk("rdata_zero", d, core_rdata[d], 32'h0);
    if (ms_v[d] && cyc >= mresp_c[d]) ms_v[d] = 1'b0;
    if (core_req[d] && core_ack[d]) begin
      out_v[d]    = 1'b1;
      out_r[d]    = gen[d];
      acc_c[d]    = cyc;
      gen_pend[d] = 1'b0;
      obs_lat[d]  = -1;
      acc_hist.push_back(cyc);
      lerr[d] = ac(d) && (gen[d].addr[1:0] != 2'b00);
      if (lerr[d]) begin
        exp_resp[d] = SCR1_MEM_RESP_RDY_ER;
        exp_c[d]    = cyc + 1;
      end else begin
        mack_c[d]   = cyc + 1 + gen[d].aw;
        mresp_c[d]  = mack_c[d] + 1 + gen[d].rw;
        exp_c[d]    = mresp_c[d] + int'(rr(d));
        exp_resp[d] = gen[d].er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        ms_v[d]     = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      bit in_data;
      in_data = ms_v[d] && (cyc > mack_c[d]) && (cyc < mresp_c[d]);
      if (ms_v[d] && cyc == mack_c[d]) mem_ack[d] = 1'b1;
      else if (!ms_v[d] || cyc > mack_c[d]) mem_ack[d] = ($urandom_range(0, 3) == 0);
      else mem_ack[d] = 1'b0;
      mem_rdata[d] = $urandom;
      if (ms_v[d] && cyc == mresp_c[d]) begin
        mem_resp[d]  = out_r[d].er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        mem_rdata[d] = out_r[d].data;
      end else if (!in_data && $urandom_range(0, 99) < stray_pct) begin
        mem_resp[d] = ($urandom_range(0, 1) == 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
      end else begin
        mem_resp[d] = SCR1_MEM_RESP_NOTRDY;
      end
      if (!gen_pend[d]) begin
        if (dq.size() > 0 && dq[0].d == d) begin
          gen[d] = dq.pop_front();
          gen_pend[d] = 1'b1;
        end else if (rnd_en && $urandom_range(0, 1) == 1) begin
          gen[d] = rand_req(d);
          gen_pend[d] = 1'b1;
        end
      end
      core_req[d]  = gen_pend[d];
      core_addr[d] = gen_pend[d] ? gen[d].addr : $urandom;
      core_cmd[d]  = gen_pend[d] ? gen[d].cmd :
                     (($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_dut(d);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < ND; d++) begin
      chk("rst_core_resp", d, 32'(core_resp[d]), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_core_ack", d, 32'(core_ack[d]), 32'h1);
      chk("rst_mem_req", d, 32'(mem_req[d]), 32'h0);
      if (rr(d)) chk("rst_core_rdata", d, core_rdata[d], 32'h0);
    end
  endtask

  function automatic bit any_pending();
    bit p;
    p = (dq.size() > 0);
    for (int d = 0; d < ND; d++) p = p | gen_pend[d] | out_v[d];
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      core_req[d] = 1'b0; core_cmd[d] = SCR1_MEM_CMD_RD; core_addr[d] = '0;
      mem_ack[d] = 1'b0; mem_rdata[d] = '0; mem_resp[d] = SCR1_MEM_RESP_NOTRDY;
      done_cnt[d] = 0; obs_lat[d] = -1;
    end
    clear_model();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    for (int d = 0; d < ND; d++) begin
      chk("rst_mem_addr", d, mem_addr[d], 32'h0);
      chk("rst_mem_cmd", d, 32'(mem_cmd[d]), 32'(SCR1_MEM_CMD_RD));
    end
    rst_n = 1'b1;

    // Directed vectors: single transactions with hand-computed response and latency
    stray_pct = 0;
    vt[0] = '{mk(2, 32'h100, SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'hDEADBEEF), SCR1_MEM_RESP_RDY_OK, 2};
    vt[1] = '{mk(3, 32'h100, SCR1_MEM_CMD_WR, 3, 0, 1'b0, 32'h0BADF00D), SCR1_MEM_RESP_RDY_OK, 6};
    vt[2] = '{mk(2, 32'h104, SCR1_MEM_CMD_WR, 1, 2, 1'b1, 32'h00000001), SCR1_MEM_RESP_RDY_ER, 5};
    vt[3] = '{mk(3, 32'h102, SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'h00000002), SCR1_MEM_RESP_RDY_ER, 1};
    vt[4] = '{mk(1, 32'h102, SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'hCAFE0102), SCR1_MEM_RESP_RDY_OK, 3};
    vt[5] = '{mk(0, 32'h106, SCR1_MEM_CMD_WR, 2, 1, 1'b0, 32'h12345678), SCR1_MEM_RESP_RDY_OK, 5};
    vt[6] = '{mk(3, 32'h108, SCR1_MEM_CMD_RD, 0, 0, 1'b1, 32'h00000003), SCR1_MEM_RESP_RDY_ER, 3};
    vt[7] = '{mk(3, 32'h10C, SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'hA5A5A5A5), SCR1_MEM_RESP_RDY_OK, 3};
    vt[8] = '{mk(2, 32'h001, SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'h00000004), SCR1_MEM_RESP_RDY_ER, 1};
    for (int i = 0; i < 9; i++) begin
      int d;
      int base;
      int n;
      d = vt[i].r.d;
      base = done_cnt[d];
      n = 0;
      dq.push_back(vt[i].r);
      while (done_cnt[d] == base && n < 60) begin
        tick();
        n++;
      end
      chk("vec_done", d, 32'(done_cnt[d]), 32'(base + 1));
      chk("vec_resp", d, 32'(obs_resp[d]), 32'(vt[i].exp_resp));
      chk("vec_lat", d, 32'(obs_lat[d]), 32'(vt[i].exp_lat));
      if (vt[i].exp_resp == SCR1_MEM_RESP_RDY_OK) chk("vec_data", d, obs_data[d], vt[i].r.data);
    end

    // Back-to-back: each new fetch accepted in the previous RDY_OK cycle
    for (int d = 2; d < 4; d++) begin
      int base;
      int n;
      base = done_cnt[d];
      n = 0;
      acc_hist.delete();
      for (int k = 0; k < 3; k++)
        dq.push_back(mk(d, 32'h200 + 32'(4 * k), SCR1_MEM_CMD_RD, 0, 0, 1'b0, 32'h5000_0000 + 32'(k)));
      while (done_cnt[d] < base + 3 && n < 60) begin
        tick();
        n++;
      end
      chk("b2b_done", d, 32'(done_cnt[d]), 32'(base + 3));
      chk("b2b_accepts", d, 32'(acc_hist.size()), 32'h3);
      if (acc_hist.size() == 3) begin
        chk("b2b_gap01", d, 32'(acc_hist[1] - acc_hist[0]), 32'(2 + int'(rr(d))));
        chk("b2b_gap12", d, 32'(acc_hist[2] - acc_hist[1]), 32'(2 + int'(rr(d))));
      end
    end

    // Reset mid-transaction: dut3 waiting in DATA, dut2 holding mem_req
    begin
      int n;
      n = 0;
      dq.push_back(mk(3, 32'h300, SCR1_MEM_CMD_RD, 0, 6, 1'b0, 32'h11111111));
      dq.push_back(mk(2, 32'h304, SCR1_MEM_CMD_RD, 6, 0, 1'b0, 32'h22222222));
      while (!(out_v[3] && out_v[2] && cyc > mack_c[3]) && n < 20) begin
        tick();
        n++;
      end
      chk("midrst_setup", 2, 32'(mem_req[2]), 32'h1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      clear_model();
      for (int d = 0; d < ND; d++) begin
        core_req[d] = 1'b0;
        mem_resp[d] = SCR1_MEM_RESP_RDY_OK;
        mem_ack[d]  = 1'b1;
      end
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      stray_pct = 100;
      repeat (5) tick();
      stray_pct = 10;
    end

    // Randomized traffic against the transaction model
    rnd_en = 1'b1;
    repeat (800) tick();
    rnd_en = 1'b0;
    begin
      int n;
      n = 0;
      while (any_pending() && n < 200) begin
        tick();
        n++;
      end
      chk("drain", 0, 32'(any_pending()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
